// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch FSM state enum, instruction size, canonical NOP encoding,
// and an alignment helper used when applying redirects.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,  // ready to issue a request once the output slot is free
    WAIT  = 2'd1,  // one request outstanding, waiting for its response
    DRAIN = 2'd2,  // outstanding response belongs to a squashed path
    HALT  = 2'd3   // stopped after a misaligned redirect
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0

  // A PC is usable only if it is word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/mux_2x1.sv
// Generic 2:1 multiplexer.
// Latency: combinational.
// Backpressure: none.
// Ports: i0 (select=0), i1 (select=1), select, y.
module MUX_2x1 #(
  parameter int Datawidth = 32
) (
  input  logic [Datawidth-1:0] i0,
  input  logic [Datawidth-1:0] i1,
  input  logic                 select,
  output logic [Datawidth-1:0] y
);

  assign y = select ? i1 : i0;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time,
// holds the returned word in a one-entry register for decode, applies redirects.
// Latency: request at N, response at N+k, if_valid at N+k+1.
// Backpressure: requests issue only when the output slot is free (!if_valid | if_ready);
// responses are never back-pressured, so the slot can never overflow.
// Ports:
//   clk, rst                         clock, async active-high reset
//   redirect_valid/redirect_target   flush and jump from execute
//   imem_req_valid/addr/ready        fetch request handshake
//   imem_rsp_valid/data              fetch response (always accepted)
//   if_valid/if_pc/if_instr/if_ready one-entry output register to decode
//   misalign_trap                    one-cycle pulse for a misaligned redirect target
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   DATAWIDTH    = 32,
  parameter logic [DATAWIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [DATAWIDTH-1:0] redirect_target,
  output logic                 imem_req_valid,
  output logic [DATAWIDTH-1:0] imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_rsp_valid,
  input  logic [DATAWIDTH-1:0] imem_rsp_data,
  output logic                 if_valid,
  output logic [DATAWIDTH-1:0] if_pc,
  output logic [DATAWIDTH-1:0] if_instr,
  input  logic                 if_ready,
  output logic                 misalign_trap
);

  fetch_state_t         state, state_nxt;
  logic [DATAWIDTH-1:0] pc;
  logic [DATAWIDTH-1:0] req_pc;
  logic [DATAWIDTH-1:0] seq_pc;
  logic [DATAWIDTH-1:0] pc_nxt;
  logic                 halt_pending;

  logic slot_free;
  logic handshake;
  logic rsp_in_wait;
  logic outstanding_after;
  logic tgt_misaligned;

  assign slot_free   = !if_valid || if_ready;
  assign handshake   = imem_req_valid && imem_req_ready;
  assign rsp_in_wait = (state == WAIT) && imem_rsp_valid;

  // A request is still in flight after this edge if we were waiting (or
  // draining) and nothing came back, or if a new request was accepted now.
  assign outstanding_after = (((state == WAIT) || (state == DRAIN)) && !imem_rsp_valid)
                             || handshake;

  assign tgt_misaligned = is_misaligned(redirect_target[1:0]);

  assign seq_pc = req_pc + DATAWIDTH'(INSTR_BYTES);

  MUX_2x1 #(
    .Datawidth(DATAWIDTH)
  ) u_next_pc_mux (
    .i0    (seq_pc),
    .i1    (redirect_target),
    .select(redirect_valid),
    .y     (pc_nxt)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      // A squashed response still has to be swallowed before anything else.
      if (outstanding_after) begin
        state_nxt = DRAIN;
      end else if (tgt_misaligned) begin
        state_nxt = HALT;
      end else begin
        state_nxt = REQ;
      end
    end else begin
      case (state)
        REQ:     if (handshake)      state_nxt = WAIT;
        WAIT:    if (imem_rsp_valid) state_nxt = REQ;
        DRAIN:   if (imem_rsp_valid) state_nxt = halt_pending ? HALT : REQ;
        HALT:    state_nxt = HALT;
        default: state_nxt = REQ;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // The reset term keeps the request line quiet while rst is held, even
  // though the reset state itself is REQ with an empty output slot.
  always_comb begin
    imem_req_valid = (state == REQ) && slot_free && !rst;
  end

  assign imem_req_addr = pc;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_VECTOR;
      req_pc       <= RESET_VECTOR;
      halt_pending <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      if (redirect_valid || rsp_in_wait) begin
        pc <= pc_nxt;
      end
      if (handshake) begin
        req_pc <= pc;
      end
      // Remembers whether the redirect that started a drain was misaligned;
      // a later redirect during the drain overrides it.
      if (redirect_valid) begin
        halt_pending <= tgt_misaligned;
      end
      if (redirect_valid) begin
        misalign_trap <= tgt_misaligned && !outstanding_after;
      end else begin
        misalign_trap <= (state == DRAIN) && imem_rsp_valid && halt_pending;
      end
    end
  end

  // Output register. A redirect kills the held word; a transfer that
  // coincides with a redirect is squashed downstream by the same pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= DATAWIDTH'(NOP_INSTR);
    end else begin
      if (redirect_valid) begin
        if_valid <= 1'b0;
      end else if (rsp_in_wait) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_instr <= imem_rsp_data;
      end else if (if_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change at the falling edge,
// outputs are compared 1 time unit later, the DUT updates on the rising edge.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign_trap;

  int passed = 0;
  int total  = 0;

  pc_fetch_unit #(
    .DATAWIDTH   (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .misalign_trap  (misalign_trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply this cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic rv, input logic [31:0] tgt, input logic rrdy,
                       input logic sv, input logic [31:0] sd, input logic ifr);
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_req_ready  = rrdy;
    imem_rsp_valid  = sv;
    imem_rsp_data   = sd;
    if_ready        = ifr;
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
    if (v) chk({tag, "_req_addr"}, imem_req_addr, a);
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, "_if_valid"}, {31'b0, if_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_if_pc"}, if_pc, p);
      chk({tag, "_if_instr"}, if_instr, i);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_instr"}, if_instr, NOP);
    chk({tag, "_trap"}, {31'b0, misalign_trap}, 32'd0);
  endtask

  task automatic chk_trap(input string tag, input logic t);
    chk({tag, "_trap"}, {31'b0, misalign_trap}, {31'b0, t});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    #1;
    chk_reset("reset");

    // ---------------- sequential fetch, k=1, if_ready=1
    nxt(); rst = 1'b0;
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_req("seq0", 1, 32'h0000_0000);
    nxt();
    drive(0, 32'h0, 1, 1, 32'h0000_00A0, 1);
    chk_req("seq0_wait", 0, 32'h0);
    chk_if("seq0_wait", 0, 32'h0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_if("seq0_out", 1, 32'h0000_0000, 32'h0000_00A0);
    chk_req("seq1", 1, 32'h0000_0004);
    nxt();
    drive(0, 32'h0, 1, 1, 32'h0000_00A4, 1);
    chk_if("seq1_gap", 0, 32'h0, 32'h0);
    chk_req("seq1_wait", 0, 32'h0);
    nxt();

    // ---------------- decode stalls with 0x4 held
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    chk_if("stall_a", 1, 32'h0000_0004, 32'h0000_00A4);
    chk_req("stall_a", 0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    chk_if("stall_b", 1, 32'h0000_0004, 32'h0000_00A4);
    chk_req("stall_b", 0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_req("resume", 1, 32'h0000_0008);
    nxt();
    drive(0, 32'h0, 1, 1, 32'h0000_00A8, 1);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_if("seq2_out", 1, 32'h0000_0008, 32'h0000_00A8);
    chk_req("seq3", 1, 32'h0000_000C);
    nxt();

    // ---------------- redirect 0x100 while waiting, response at k=3
    drive(1, 32'h0000_0100, 1, 0, 32'h0, 1);
    chk_req("rd_wait", 0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_req("drain_a", 0, 32'h0);
    chk_if("drain_a", 0, 32'h0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 1, 32'hDEAD_DEAD, 1);
    chk_req("drain_rsp", 0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_if("stale_dropped", 0, 32'h0, 32'h0);
    chk_req("after_drain", 1, 32'h0000_0100);
    nxt();

    // ---------------- redirect 0x200 together with the response
    drive(1, 32'h0000_0200, 1, 1, 32'hBEEF_BEEF, 1);
    nxt();
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    chk_if("rd_rsp_drop", 0, 32'h0, 32'h0);
    chk_req("rd_rsp_next", 1, 32'h0000_0200);
    nxt();

    // ---------------- misaligned redirect 0x102 with nothing in flight
    drive(1, 32'h0000_0102, 0, 0, 32'h0, 1);
    chk_trap("pre_trap", 0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_trap("trap_pulse", 1);
    chk_req("halt_a", 0, 32'h0);
    chk_if("halt_a", 0, 32'h0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_trap("trap_end", 0);
    chk_req("halt_b", 0, 32'h0);
    nxt();
    drive(1, 32'h0000_0300, 1, 0, 32'h0, 1);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_req("halt_exit", 1, 32'h0000_0300);
    chk_trap("halt_exit", 0);
    nxt();
    drive(0, 32'h0, 1, 1, 32'h0000_0333, 1);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_if("after_halt", 1, 32'h0000_0300, 32'h0000_0333);
    chk_req("seq_304", 1, 32'h0000_0304);
    nxt();

    // ---------------- misaligned redirect with a request in flight
    drive(1, 32'h0000_0306, 1, 0, 32'h0, 1);
    nxt();
    drive(0, 32'h0, 1, 1, 32'h1111_1111, 1);
    chk_trap("mis_drain_wait", 0);
    chk_req("mis_drain_wait", 0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_trap("mis_drain_trap", 1);
    chk_req("mis_drain_halt", 0, 32'h0);
    chk_if("mis_drain_halt", 0, 32'h0, 32'h0);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_trap("mis_drain_end", 0);
    chk_req("mis_drain_halt2", 0, 32'h0);
    nxt();

    // ---------------- PC wrap at the top of the address space
    drive(1, 32'hFFFF_FFFC, 1, 0, 32'h0, 1);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_req("top_req", 1, 32'hFFFF_FFFC);
    nxt();
    drive(0, 32'h0, 1, 1, 32'h0000_0077, 1);
    nxt();
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_if("top_out", 1, 32'hFFFF_FFFC, 32'h0000_0077);
    chk_req("wrap_req", 1, 32'h0000_0000);
    nxt();

    // ---------------- asynchronous reset while waiting
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    nxt();
    rst = 1'b0;
    drive(0, 32'h0, 1, 0, 32'h0, 1);
    chk_req("post_rst", 1, 32'h0000_0000);
    nxt();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
